// File: rtl/calculadora_pkg.sv
// Shared definitions for the register-file calculator: opcodes and FSM states.
package calculadora_pkg;

    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/calculadora_alu.sv
// Combinational ALU: eight operations with carry/borrow and signed-overflow outputs.
module calculadora_alu
    import calculadora_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] imm,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         ovf
);

    logic [W:0] sum;
    logic [W:0] diff;

    // Extra top bit holds carry-out for ADD and borrow for SUB.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_LDI: result = imm;
            OP_ADD: begin
                result = sum[W-1:0];
                carry  = sum[W];
                ovf    = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
            end
            OP_SUB: begin
                result = diff[W-1:0];
                carry  = diff[W];
                ovf    = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
            end
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_XOR: result = A ^ B;
            OP_SLT: result = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_MOV: result = A;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/calculadora_fsm.sv
// Register-file calculator: IDLE -> READ -> EXEC -> WB, one op per four cycles,
// with combinational readback port and flags of the last completed operation.
module calculadora_fsm
    import calculadora_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         opera,
    input  logic [2:0]   op,
    input  logic [R-1:0] rd,
    input  logic [R-1:0] rs1,
    input  logic [R-1:0] rs2,
    input  logic [W-1:0] imm,
    input  logic [R-1:0] read,
    output logic [W-1:0] data,
    output logic         busy,
    output logic         done,
    output logic         zero,
    output logic         carry,
    output logic         ovf
);

    localparam int unsigned NREG = 2 ** R;

    state_t       state;
    logic [2:0]   op_q;
    logic [R-1:0] rd_q;
    logic [R-1:0] rs1_q;
    logic [R-1:0] rs2_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] res_q;
    logic         res_c;
    logic         res_o;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_o;
    logic [W-1:0] regs [NREG];

    calculadora_alu #(.W(W)) u_alu (
        .op     (op_q),
        .A      (a_q),
        .B      (b_q),
        .imm    (imm_q),
        .result (alu_res),
        .carry  (alu_c),
        .ovf    (alu_o)
    );

    // Register 0 is never written, so it reads zero on both ports.
    assign data = regs[read];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            res_c <= 1'b0;
            res_o <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            zero  <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i[R-1:0]] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (opera) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        imm_q <= imm;
                        busy  <= 1'b1;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    a_q   <= regs[rs1_q];
                    b_q   <= regs[rs2_q];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    res_c <= alu_c;
                    res_o <= alu_o;
                    state <= S_WB;
                end
                S_WB: begin
                    if (rd_q != '0) begin
                        regs[rd_q] <= res_q;
                    end
                    zero  <= (res_q == '0);
                    carry <= res_c;
                    ovf   <= res_o;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calculadora_fsm.sv
// Scoreboard bench: stimulus queues expected write-back values and flags; a
// monitor pops and compares on every done pulse.
module tb_calculadora_fsm;
    import calculadora_pkg::*;

    localparam int W = 32;
    localparam int R = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         opera = 1'b0;
    logic [2:0]   op    = '0;
    logic [R-1:0] rd    = '0;
    logic [R-1:0] rs1   = '0;
    logic [R-1:0] rs2   = '0;
    logic [W-1:0] imm   = '0;
    logic [R-1:0] read  = '0;
    logic [W-1:0] data;
    logic         busy;
    logic         done;
    logic         zero;
    logic         carry;
    logic         ovf;

    typedef struct {
        logic [W-1:0] data;
        logic         z;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    calculadora_fsm #(.W(W), .R(R)) dut (
        .clock (clock),
        .reset (reset),
        .opera (opera),
        .op    (op),
        .rd    (rd),
        .rs1   (rs1),
        .rs2   (rs2),
        .imm   (imm),
        .read  (read),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .carry (carry),
        .ovf   (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                e = exp_q.pop_front();
                check("wb_data", data, e.data);
                check("wb_zero", W'(zero), W'(e.z));
                check("wb_carry", W'(carry), W'(e.c));
                check("wb_ovf", W'(ovf), W'(e.o));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input int unsigned d, input int unsigned s1,
                         input int unsigned s2, input logic [W-1:0] im, input logic [W-1:0] ed,
                         input logic ez, input logic ec, input logic eo, input bit poke);
        exp_t e;
        int   n;
        bit   seen;
        op    = o;
        rd    = R'(d);
        rs1   = R'(s1);
        rs2   = R'(s2);
        imm   = im;
        read  = R'(d);
        opera = 1'b1;
        e.data = ed;
        e.z    = ez;
        e.c    = ec;
        e.o    = eo;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        opera = 1'b0;
        check("busy_after_start", W'(busy), W'(1));
        op  = 3'($urandom);
        rd  = R'($urandom);
        rs1 = R'($urandom);
        rs2 = R'($urandom);
        imm = $urandom;
        if (poke) begin
            opera = 1'b1;
            op    = OP_LDI;
            rd    = R'(21);
            imm   = 32'h55;
        end
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 10) begin
            @(posedge clock);
            #1;
            n++;
            if (poke && n == 1) opera = 1'b0;
            seen = done;
        end
        check("done_latency", W'(n), W'(3));
        check("busy_at_done", W'(busy), W'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        bit any_done;
        int cnt;

        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_flags", W'({zero, carry, ovf}), W'(0));
        reset = 1'b0;

        // Leave non-zero flags behind, then reset in the middle of EXEC.
        issue(OP_LDI, 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0);
        issue(OP_ADD, 2, 1, 1, 0, 32'h0000_0000, 1, 1, 1, 0);
        op = OP_ADD; rd = R'(1); rs1 = R'(1); rs2 = R'(1); read = R'(1); opera = 1'b1;
        @(posedge clock);
        #1 opera = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("midop_rst_busy", W'(busy), W'(0));
        check("midop_rst_done", W'(done), W'(0));
        check("midop_rst_zero", W'(zero), W'(0));
        check("midop_rst_carry", W'(carry), W'(0));
        check("midop_rst_ovf", W'(ovf), W'(0));
        for (int i = 0; i < 32; i++) begin
            read = R'(i);
            #1 check("rst_regs", data, '0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        any_done = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1 any_done |= done;
        end
        check("no_done_after_rst", W'(any_done), W'(0));

        issue(OP_LDI, 1, 0, 0, 32'd5, 32'd5, 0, 0, 0, 0);
        issue(OP_LDI, 2, 0, 0, 32'd7, 32'd7, 0, 0, 0, 0);
        issue(OP_ADD, 3, 1, 2, 0, 32'd12, 0, 0, 0, 0);
        issue(OP_SUB, 4, 1, 2, 0, 32'hFFFF_FFFE, 0, 1, 0, 0);
        issue(OP_LDI, 7, 0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, 0);
        issue(OP_LDI, 8, 0, 0, 32'd1, 32'd1, 0, 0, 0, 0);
        issue(OP_ADD, 9, 7, 8, 0, 32'h8000_0000, 0, 0, 1, 0);
        issue(OP_LDI, 10, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        issue(OP_ADD, 11, 10, 8, 0, 32'h0000_0000, 1, 1, 0, 0);
        issue(OP_LDI, 0, 0, 0, 32'd9, 32'd0, 0, 0, 0, 0);
        issue(OP_SLT, 5, 10, 8, 0, 32'd1, 0, 0, 0, 0);
        issue(OP_SLT, 16, 8, 10, 0, 32'd0, 1, 0, 0, 0);
        issue(OP_XOR, 6, 2, 2, 0, 32'd0, 1, 0, 0, 0);
        issue(OP_AND, 12, 10, 2, 0, 32'd7, 0, 0, 0, 0);
        issue(OP_OR, 13, 1, 2, 0, 32'd7, 0, 0, 0, 0);
        issue(OP_MOV, 14, 9, 0, 0, 32'h8000_0000, 0, 0, 0, 0);
        issue(OP_SUB, 15, 2, 1, 0, 32'd2, 0, 0, 0, 0);
        issue(OP_SUB, 17, 9, 8, 0, 32'h7FFF_FFFF, 0, 0, 1, 0);

        // Back-to-back: opera held for 20 edges gives starts at 0,4,8,12,16.
        issue(OP_LDI, 1, 0, 0, 32'd1, 32'd1, 0, 0, 0, 0);
        issue(OP_LDI, 2, 0, 0, 32'd1, 32'd1, 0, 0, 0, 0);
        op = OP_ADD; rd = R'(1); rs1 = R'(1); rs2 = R'(2); read = R'(1); imm = '0;
        for (int v = 2; v <= 6; v++) begin
            exp_t e;
            e.data = W'(v);
            e.z = 1'b0;
            e.c = 1'b0;
            e.o = 1'b0;
            exp_q.push_back(e);
        end
        opera = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                check("b2b_spacing", W'(k), W'(4 * cnt + 3));
                cnt++;
            end
        end
        opera = 1'b0;
        check("b2b_count", W'(cnt), W'(5));
        repeat (2) @(posedge clock);
        #1 check("b2b_final_r1", data, 32'd6);

        // Start pulsed while busy must be ignored.
        issue(OP_ADD, 20, 1, 1, 0, 32'd12, 0, 0, 0, 1);
        read = R'(21);
        #1 check("ignored_start_r21", data, 32'd0);
        read = R'(20);
        #1 check("ignored_start_r20", data, 32'd12);

        repeat (6) @(posedge clock);
        #1 check("queue_empty", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
